int_claim_ctrl: RTL and testbench

Interrupt gateway, arbiter and claim/complete controller for the interrupt block. It consumes the per-source enable and priority register values plus a priority threshold, and latches level interrupt requests into pending bits. It selects the highest-priority eligible source, drives the core interrupt line, and serves claim/complete accesses on the same register bus used by the enable/priority registers.

---
 rtl/int_pkg.sv | 20 ++
 rtl/int_gateway.sv | 41 ++++
 rtl/int_claim_ctrl.sv | 133 +++++++++++++
 tb/tb_int_claim_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared defaults and ID helpers for the interrupt claim controller
//
// Contents:
//   DEF_NUM_SRC / DEF_PRIO_W / DEF_ID_W : default source count, priority width and ID width
//   DEF_CLAIM_ADDR / DEF_PEND_ADDR      : default claim/complete and pending-vector addresses
//   id_to_idx()                         : maps an interrupt ID (1-based, 0 = none) to a source index
package int_pkg;

    localparam int          DEF_NUM_SRC    = 16;
    localparam int          DEF_PRIO_W     = 3;
    localparam int          DEF_ID_W       = 5;
    localparam logic [31:0] DEF_CLAIM_ADDR = 32'h0000_0200;
    localparam logic [31:0] DEF_PEND_ADDR  = 32'h0000_0204;

    // ID 0 means "no source"; it maps to index -1, which matches no gateway.
    function automatic int id_to_idx(input int id);
        return id - 1;
    endfunction

endpackage

// File: rtl/int_gateway.sv
// rtl/int_gateway.sv - per-source level gateway holding the pending and in_service flops
//
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   irq         : level request from the source
//   claim       : this source's ID is being claimed this cycle
//   complete    : a valid complete for this source's ID is being written this cycle
//   pending     : request latched, waiting to be claimed
//   in_service  : claimed and not yet completed; blocks re-pending
module int_gateway (
    input  logic clk,
    input  logic rstn,
    input  logic irq,
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic in_service
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            // Claim wins over a simultaneous request so a held level cannot
            // re-pend on the claim edge.
            if (claim) begin
                pending <= 1'b0;
            end else if (irq && !pending && !in_service) begin
                pending <= 1'b1;
            end

            if (claim) begin
                in_service <= 1'b1;
            end else if (complete) begin
                in_service <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/int_claim_ctrl.sv
// rtl/int_claim_ctrl.sv - interrupt gateways, priority arbiter and claim/complete register decode
//
// Ports:
//   clk, rstn           : clock, asynchronous active-low reset
//   src_irq             : level interrupt requests
//   int_en, int_prio    : per-source enable and priority (source i at [i*PRIO_W +: PRIO_W])
//   threshold           : only priorities strictly above this interrupt
//   reg_en/reg_wr       : register access strobe and direction
//   reg_addr/reg_wdata  : register address and write data
//   reg_rdata           : registered read data
//   irq_out             : registered interrupt to the core
module int_claim_ctrl
    import int_pkg::*;
#(
    parameter int          NUM_SRC    = DEF_NUM_SRC,
    parameter int          PRIO_W     = DEF_PRIO_W,
    parameter int          ID_W       = DEF_ID_W,
    parameter logic [31:0] CLAIM_ADDR = DEF_CLAIM_ADDR,
    parameter logic [31:0] PEND_ADDR  = DEF_PEND_ADDR
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_SRC-1:0]        src_irq,
    input  logic [NUM_SRC-1:0]        int_en,
    input  logic [NUM_SRC*PRIO_W-1:0] int_prio,
    input  logic [PRIO_W-1:0]         threshold,
    input  logic                      reg_en,
    input  logic                      reg_wr,
    input  logic [31:0]               reg_addr,
    input  logic [31:0]               reg_wdata,
    output logic [31:0]               reg_rdata,
    output logic                      irq_out
);

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] claim_vec;
    logic [NUM_SRC-1:0] complete_vec;

    logic [ID_W-1:0]    best_id;
    logic               best_valid;

    logic               rd_claim;
    logic               rd_pend;
    logic               rd_other;
    logic               wr_claim;
    logic               claim_go;
    logic [ID_W-1:0]    cmp_id;
    logic               cmp_in_range;
    logic               unused_wdata;

    logic               arb_valid;
    logic [ID_W-1:0]    arb_id;
    logic [PRIO_W-1:0]  arb_prio;

    // Bus decode
    assign rd_claim = reg_en && !reg_wr && (reg_addr == CLAIM_ADDR);
    assign rd_pend  = reg_en && !reg_wr && (reg_addr == PEND_ADDR);
    assign rd_other = reg_en && !reg_wr && !rd_claim && !rd_pend;
    assign wr_claim = reg_en &&  reg_wr && (reg_addr == CLAIM_ADDR);

    // A claim only takes a source when the registered winner is valid.
    assign claim_go = rd_claim && best_valid;

    assign cmp_id       = reg_wdata[ID_W-1:0];
    assign cmp_in_range = (cmp_id != '0) && (int'(cmp_id) <= NUM_SRC);
    assign unused_wdata = ^reg_wdata[31:ID_W];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign claim_vec[i]    = claim_go && (id_to_idx(int'(best_id)) == i);
        // A complete for a source not in service is harmless: the gateway
        // only acts on it when in_service is set.
        assign complete_vec[i] = wr_claim && cmp_in_range && (id_to_idx(int'(cmp_id)) == i);
        assign eligible[i]     = pending[i] && int_en[i] &&
                                 (int_prio[i*PRIO_W +: PRIO_W] > threshold);

        int_gateway u_gw (
            .clk        (clk),
            .rstn       (rstn),
            .irq        (src_irq[i]),
            .claim      (claim_vec[i]),
            .complete   (complete_vec[i]),
            .pending    (pending[i]),
            .in_service (in_service[i])
        );
    end

    // Ascending scan with a strict compare keeps the lowest ID on ties.
    // Any eligible source has priority >= 1, so starting from 0 is safe.
    always_comb begin
        arb_valid = 1'b0;
        arb_id    = '0;
        arb_prio  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (int_prio[i*PRIO_W +: PRIO_W] > arb_prio)) begin
                arb_valid = 1'b1;
                arb_prio  = int_prio[i*PRIO_W +: PRIO_W];
                arb_id    = ID_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            best_id    <= '0;
            best_valid <= 1'b0;
            irq_out    <= 1'b0;
            reg_rdata  <= '0;
        end else begin
            // A claim blanks the winner for one cycle so the same ID cannot be
            // claimed twice before its pending bit has cleared.
            if (rd_claim) begin
                best_id    <= '0;
                best_valid <= 1'b0;
                irq_out    <= 1'b0;
            end else begin
                best_id    <= arb_id;
                best_valid <= arb_valid;
                irq_out    <= arb_valid;
            end

            if (rd_claim) begin
                reg_rdata <= best_valid ? {{(32-ID_W){1'b0}}, best_id} : 32'h0;
            end else if (rd_pend) begin
                reg_rdata <= 32'(pending);
            end else if (rd_other) begin
                reg_rdata <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_int_claim_ctrl.sv
// tb/tb_int_claim_ctrl.sv - directed self-checking bench for int_claim_ctrl
module tb_int_claim_ctrl;

    localparam logic [31:0] CLAIM = 32'h0000_0200;
    localparam logic [31:0] PEND  = 32'h0000_0204;

    logic        clk;
    logic        rstn;
    logic [15:0] src_irq;
    logic [15:0] int_en;
    logic [47:0] int_prio;
    logic [2:0]  threshold;
    logic        reg_en;
    logic        reg_wr;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        irq_out;

    int checks;
    int failures;

    int_claim_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .src_irq   (src_irq),
        .int_en    (int_en),
        .int_prio  (int_prio),
        .threshold (threshold),
        .reg_en    (reg_en),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .irq_out   (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        src_irq   = '0;
        int_en    = '0;
        int_prio  = '0;
        threshold = '0;
        reg_en    = 1'b0;
        reg_wr    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        ticks(2);
        rstn = 1'b1;
    endtask

    task automatic set_src(input int idx, input logic [2:0] p);
        int_prio[idx*3 +: 3] = p;
        int_en[idx]          = 1'b1;
        src_irq[idx]         = 1'b1;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
        reg_en   = 1'b1;
        reg_wr   = 1'b0;
        reg_addr = addr;
        tick();
        d      = reg_rdata;
        reg_en = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] d);
        reg_en    = 1'b1;
        reg_wr    = 1'b1;
        reg_addr  = addr;
        reg_wdata = d;
        tick();
        reg_en = 1'b0;
        reg_wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        checks++;
        if (irq_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b exp=0", irq_out);
        end
        checks++;
        if (reg_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0", reg_rdata);
        end
        bus_read(PEND, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_pend got=%h exp=0", d);
        end
    endtask

    task automatic test_single();
        logic [31:0] d;
        do_reset();
        set_src(3, 3'd2);
        tick();
        checks++;
        if (irq_out !== 1'b0) begin
            failures++;
            $display("FAIL single_lat1 got=%b exp=0", irq_out);
        end
        tick();
        checks++;
        if (irq_out !== 1'b1) begin
            failures++;
            $display("FAIL single_lat2 got=%b exp=1", irq_out);
        end
        bus_read(CLAIM, d);
        checks++;
        if (d !== 32'd4) begin
            failures++;
            $display("FAIL single_claim got=%h exp=4", d);
        end
        checks++;
        if (irq_out !== 1'b0) begin
            failures++;
            $display("FAIL single_drop got=%b exp=0", irq_out);
        end
        tick();
        checks++;
        if (irq_out !== 1'b0) begin
            failures++;
            $display("FAIL single_stay_low got=%b exp=0", irq_out);
        end
        bus_write(CLAIM, 32'd4);
        tick();
        checks++;
        if (irq_out !== 1'b0) begin
            failures++;
            $display("FAIL single_repend1 got=%b exp=0", irq_out);
        end
        tick();
        checks++;
        if (irq_out !== 1'b1) begin
            failures++;
            $display("FAIL single_repend2 got=%b exp=1", irq_out);
        end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        do_reset();
        set_src(1, 3'd3);
        set_src(5, 3'd3);
        set_src(2, 3'd5);
        ticks(2);
        checks++;
        if (irq_out !== 1'b1) begin
            failures++;
            $display("FAIL prio_irq got=%b exp=1", irq_out);
        end
        bus_read(CLAIM, d);
        checks++;
        if (d !== 32'd3) begin
            failures++;
            $display("FAIL prio_claim1 got=%h exp=3", d);
        end
        src_irq[2] = 1'b0;
        bus_write(CLAIM, 32'd3);
        bus_read(CLAIM, d);
        checks++;
        if (d !== 32'd2) begin
            failures++;
            $display("FAIL prio_claim2 got=%h exp=2", d);
        end
        src_irq[1] = 1'b0;
        bus_write(CLAIM, 32'd2);
        bus_read(CLAIM, d);
        checks++;
        if (d !== 32'd6) begin
            failures++;
            $display("FAIL prio_claim3 got=%h exp=6", d);
        end
        src_irq[5] = 1'b0;
        bus_write(CLAIM, 32'd6);
        tick();
        bus_read(CLAIM, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL prio_claim_empty got=%h exp=0", d);
        end
    endtask

    task automatic test_threshold_enable();
        logic [31:0] d;
        do_reset();
        threshold = 3'd2;
        set_src(0, 3'd2);
        ticks(3);
        checks++;
        if (irq_out !== 1'b0) begin
            failures++;
            $display("FAIL thr_equal got=%b exp=0", irq_out);
        end
        int_prio[2:0] = 3'd3;
        tick();
        checks++;
        if (irq_out !== 1'b1) begin
            failures++;
            $display("FAIL thr_above got=%b exp=1", irq_out);
        end
        int_en[0] = 1'b0;
        tick();
        checks++;
        if (irq_out !== 1'b0) begin
            failures++;
            $display("FAIL en_off got=%b exp=0", irq_out);
        end
        bus_write(PEND, 32'h0);
        bus_read(PEND, d);
        checks++;
        if (d !== 32'h0000_0001) begin
            failures++;
            $display("FAIL en_off_pend got=%h exp=00000001", d);
        end
        tick();
        checks++;
        if (reg_rdata !== 32'h0000_0001) begin
            failures++;
            $display("FAIL rdata_hold got=%h exp=00000001", reg_rdata);
        end
        bus_read(32'h0000_0100, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL other_read got=%h exp=0", d);
        end
    endtask

    task automatic test_empty_and_bad_complete();
        logic [31:0] d;
        do_reset();
        bus_read(CLAIM, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL empty_claim got=%h exp=0", d);
        end
        bus_read(PEND, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL empty_pend got=%h exp=0", d);
        end
        set_src(0, 3'd1);
        ticks(2);
        bus_write(CLAIM, 32'd1);
        tick();
        checks++;
        if (irq_out !== 1'b1) begin
            failures++;
            $display("FAIL notinsvc_complete got=%b exp=1", irq_out);
        end
        bus_read(CLAIM, d);
        checks++;
        if (d !== 32'd1) begin
            failures++;
            $display("FAIL bad_claim got=%h exp=1", d);
        end
        bus_write(CLAIM, 32'd0);
        bus_write(CLAIM, 32'd17);
        bus_write(CLAIM, 32'd2);
        ticks(2);
        bus_read(PEND, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL bad_complete_pend got=%h exp=0", d);
        end
        checks++;
        if (irq_out !== 1'b0) begin
            failures++;
            $display("FAIL bad_complete_irq got=%b exp=0", irq_out);
        end
        bus_write(CLAIM, 32'd1);
        ticks(2);
        bus_read(PEND, d);
        checks++;
        if (d !== 32'h0000_0001) begin
            failures++;
            $display("FAIL good_complete_pend got=%h exp=00000001", d);
        end
    endtask

    task automatic test_race();
        logic [31:0] d;
        do_reset();
        set_src(7, 3'd1);
        ticks(2);
        bus_read(CLAIM, d);
        checks++;
        if (d !== 32'd8) begin
            failures++;
            $display("FAIL race_claim got=%h exp=8", d);
        end
        bus_read(PEND, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL race_pend got=%h exp=0", d);
        end
        ticks(2);
        checks++;
        if (irq_out !== 1'b0) begin
            failures++;
            $display("FAIL race_irq got=%b exp=0", irq_out);
        end
        bus_read(CLAIM, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL race_second_claim got=%h exp=0", d);
        end
        bus_write(CLAIM, 32'd8);
        ticks(2);
        bus_read(PEND, d);
        checks++;
        if (d !== 32'h0000_0080) begin
            failures++;
            $display("FAIL race_repend got=%h exp=00000080", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        do_reset();
        set_src(2, 3'd4);
        ticks(2);
        bus_read(CLAIM, d);
        ticks(2);
        rstn = 1'b0;
        #1;
        checks++;
        if (irq_out !== 1'b0 || reg_rdata !== 32'h0) begin
            failures++;
            $display("FAIL midrst_outputs got=%b/%h exp=0/0", irq_out, reg_rdata);
        end
        ticks(2);
        rstn = 1'b1;
        tick();
        checks++;
        if (irq_out !== 1'b0) begin
            failures++;
            $display("FAIL midrst_lat1 got=%b exp=0", irq_out);
        end
        tick();
        checks++;
        if (irq_out !== 1'b1) begin
            failures++;
            $display("FAIL midrst_lat2 got=%b exp=1", irq_out);
        end
        bus_read(CLAIM, d);
        checks++;
        if (d !== 32'd3) begin
            failures++;
            $display("FAIL midrst_claim got=%h exp=3", d);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_priority();
        test_threshold_enable();
        test_empty_and_bad_complete();
        test_race();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
